// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round functions and FSM state codes
package sha256_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round; element 0 is A, element 7 is H
module sha256_round
    import sha256_pkg::*;
(
    input  logic [7:0][31:0] st_in,
    input  logic [31:0]      k_in,
    input  logic [31:0]      w_in,
    output logic [7:0][31:0] st_out
);

    logic [31:0] t1;
    logic [31:0] t2;

    // T1/T2 mix, then the working words shift down by one with A and E replaced
    always_comb begin
        t1 = st_in[7] + big_sigma1(st_in[4]) + ch(st_in[4], st_in[5], st_in[6]) + k_in + w_in;
        t2 = big_sigma0(st_in[0]) + maj(st_in[0], st_in[1], st_in[2]);
        st_out[0] = t1 + t2;
        st_out[1] = st_in[0];
        st_out[2] = st_in[1];
        st_out[3] = st_in[2];
        st_out[4] = st_in[3] + t1;
        st_out[5] = st_in[4];
        st_out[6] = st_in[5];
        st_out[7] = st_in[6];
    end

endmodule

// File: rtl/sha256_round_core.sv
// rtl/sha256_round_core.sv - SHA-256 compression engine with unrolled rounds and feed-forward
module sha256_round_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS   = 64,
    parameter int UNROLL   = 1,
    parameter int FEED_FWD = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_en,
    input  logic [2:0]              ld_addr,
    input  logic [31:0]             ld_data,
    input  logic                    start,
    input  logic                    w_valid,
    input  logic [32*UNROLL-1:0]    w_data,
    output logic                    w_ready,
    output logic                    busy,
    output logic                    done,
    input  logic [2:0]              rd_addr,
    output logic [31:0]             rd_data
);

    logic [7:0][31:0] work_q, work_d;
    logic [7:0][31:0] init_q, init_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             fin_q, fin_d;
    logic             done_q, done_d;

    logic [UNROLL:0][7:0][31:0] chain;
    logic                       last_beat;

    assign chain[0] = work_q;

    genvar u;
    generate
        for (u = 0; u < UNROLL; u++) begin : g_round
            logic [5:0] k_idx;
            assign k_idx = cnt_q[5:0] + 6'(u);
            sha256_round u_round (
                .st_in  (chain[u]),
                .k_in   (K[k_idx]),
                .w_in   (w_data[32*u +: 32]),
                .st_out (chain[u+1])
            );
        end
    endgenerate

    assign last_beat = (cnt_q + 7'(UNROLL)) == 7'(ROUNDS);

    // Next-state: loads in IDLE, rounds per accepted beat in RUN, feed-forward add in FINAL.
    // fin marks block completion; done follows it one cycle later.
    always_comb begin
        work_d  = work_q;
        init_d  = init_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        fin_d   = 1'b0;
        done_d  = fin_q;
        case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < 8; i++) begin
                    if (ld_en && ld_addr == 3'(i)) begin
                        work_d[i] = ld_data;
                        init_d[i] = ld_data;
                    end
                end
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (w_valid) begin
                    work_d = chain[UNROLL];
                    cnt_d  = cnt_q + 7'(UNROLL);
                    if (last_beat) begin
                        if (FEED_FWD != 0) begin
                            state_d = ST_FINAL;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            fin_d   = 1'b1;
                        end
                    end
                end
            end
            ST_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    work_d[i] = work_q[i] + init_q[i];
                    init_d[i] = work_q[i] + init_q[i];
                end
                cnt_d   = '0;
                state_d = ST_IDLE;
                fin_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register update; reset restores the IV and aborts any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= IV[i];
                init_q[i] <= IV[i];
            end
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            work_q  <= work_d;
            init_q  <= init_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
        end
    end

    assign w_ready = (state_q == ST_RUN);
    assign busy    = (state_q == ST_RUN) || (state_q == ST_FINAL);
    assign done    = done_q;
    assign rd_data = work_q[rd_addr];

endmodule
